// File: rtl/dependency_check_block.sv
// Decode-stage hazard detector: tracks the last three register writers and picks operand forwarding sources.
// Latency: one edge for decode outputs; RW_dm/wr_en_dm report the instruction sampled two edges earlier.
module dependency_check_block (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] ins,
    input  logic        ins_valid,
    output logic [7:0]  imm,
    output logic        imm_sel,
    output logic [2:0]  mux_sel_A,
    output logic [2:0]  mux_sel_B,
    output logic [4:0]  RW_dm,
    output logic        wr_en_dm
);

    localparam logic [2:0] SEL_RF = 3'd0;
    localparam logic [2:0] SEL_EX = 3'd1;
    localparam logic [2:0] SEL_DM = 3'd2;
    localparam logic [2:0] SEL_WB = 3'd3;

    logic [5:0] opcode;
    logic [4:0] rd;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       writes_reg;
    logic       is_imm;

    // Producer history, d1 youngest; RD is zeroed whenever the entry is invalid.
    logic       d1_valid;
    logic [4:0] d1_rd;
    logic       d2_valid;
    logic [4:0] d2_rd;
    logic       d3_valid;
    logic [4:0] d3_rd;

    logic       new_valid;
    logic [4:0] new_rd;
    logic [2:0] fwd_a;
    logic [2:0] fwd_b;
    logic [7:0] imm_next;
    logic       imm_sel_next;
    logic [2:0] sel_a_next;
    logic [2:0] sel_b_next;

    assign opcode = ins[23:18];
    assign rd     = ins[17:13];
    assign ra     = ins[12:8];
    assign rb     = ins[7:3];

    assign writes_reg = ins_valid && (opcode != 6'd0) && (opcode[5:4] != 2'b11);
    assign is_imm     = ins_valid && (opcode[5:4] == 2'b01);

    // R0 is hardwired, so a write to it must never become a forwarding source.
    assign new_valid = writes_reg && (rd != 5'd0);
    assign new_rd    = new_valid ? rd : 5'd0;

    always_comb begin
        fwd_a = SEL_RF;
        if (d1_valid && (d1_rd == ra)) begin
            fwd_a = SEL_EX;
        end else if (d2_valid && (d2_rd == ra)) begin
            fwd_a = SEL_DM;
        end else if (d3_valid && (d3_rd == ra)) begin
            fwd_a = SEL_WB;
        end
    end

    always_comb begin
        fwd_b = SEL_RF;
        if (d1_valid && (d1_rd == rb)) begin
            fwd_b = SEL_EX;
        end else if (d2_valid && (d2_rd == rb)) begin
            fwd_b = SEL_DM;
        end else if (d3_valid && (d3_rd == rb)) begin
            fwd_b = SEL_WB;
        end
    end

    always_comb begin
        imm_next     = 8'h00;
        imm_sel_next = 1'b0;
        sel_a_next   = SEL_RF;
        sel_b_next   = SEL_RF;
        if (ins_valid) begin
            sel_a_next = fwd_a;
            if (is_imm) begin
                imm_next     = ins[7:0];
                imm_sel_next = 1'b1;
            end else begin
                sel_b_next = fwd_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_valid <= 1'b0;
            d1_rd    <= 5'd0;
            d2_valid <= 1'b0;
            d2_rd    <= 5'd0;
            d3_valid <= 1'b0;
            d3_rd    <= 5'd0;
        end else begin
            d3_valid <= d2_valid;
            d3_rd    <= d2_rd;
            d2_valid <= d1_valid;
            d2_rd    <= d1_rd;
            d1_valid <= new_valid;
            d1_rd    <= new_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imm       <= 8'h00;
            imm_sel   <= 1'b0;
            mux_sel_A <= SEL_RF;
            mux_sel_B <= SEL_RF;
        end else begin
            imm       <= imm_next;
            imm_sel   <= imm_sel_next;
            mux_sel_A <= sel_a_next;
            mux_sel_B <= sel_b_next;
        end
    end

    assign RW_dm    = d2_rd;
    assign wr_en_dm = d2_valid;

endmodule
